// File: rtl/rs_io_buf_bank.sv
// Bank of WIDTH bidirectional pad channels: synchronised/deglitched input path with edge
// pulses, registered output path, and a per-channel driver turnaround FSM.
module rs_io_buf_bank #(
    parameter int    WIDTH         = 8,
    parameter int    FILTER_CYCLES = 3,
    parameter int    TURNAROUND    = 2,
    parameter string WEAK_KEEPER   = "NONE"
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] out_data,
    input  logic [WIDTH-1:0] oe_req,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    output logic [WIDTH-1:0] ibuf_en,
    output logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    localparam int MAXC = (FILTER_CYCLES > TURNAROUND) ? FILTER_CYCLES : TURNAROUND;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] TCMP = (TURNAROUND > 0) ? CW'(TURNAROUND - 1) : '0;
    localparam logic [CW-1:0] FCMP = (FILTER_CYCLES > 1) ? CW'(FILTER_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    localparam logic          FBYPASS = (FILTER_CYCLES <= 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IN       = 2'd0,
        ST_TURN_OUT = 2'd1,
        ST_OUT      = 2'd2,
        ST_TURN_IN  = 2'd3
    } state_t;

    // The keeper choice only configures the external pad cells; it has no effect on this logic.
    if (WEAK_KEEPER != "NONE" && WEAK_KEEPER != "PULLUP" && WEAK_KEEPER != "PULLDOWN") begin : g_keeper_unrecognised
    end

    logic [WIDTH-1:0] r_pad_o;

    // Output data path: one register stage, independent of direction.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_pad_o <= '0;
        end else begin
            r_pad_o <= out_data;
        end
    end

    assign pad_o = r_pad_o;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t        r_state;
        state_t        w_next;
        logic [CW-1:0] r_tcnt;
        logic [CW-1:0] r_fcnt;
        logic          r_meta, r_sync, r_in, r_rise, r_fall;
        logic          r_pad_t, r_ibuf_en, r_busy;
        logic          w_pad_t, w_ibuf_en, w_busy;
        logic          w_turn_done, w_upd;

        assign w_turn_done = (r_tcnt == TCMP);

        // Next-state selection for the direction FSM.
        always_comb begin
            w_next = r_state;
            case (r_state)
                ST_IN: begin
                    if (!oe_req[g]) begin
                        w_next = ST_IN;
                    end else if (TURNAROUND == 0) begin
                        w_next = ST_OUT;
                    end else begin
                        w_next = ST_TURN_OUT;
                    end
                end
                ST_TURN_OUT: begin
                    if (!oe_req[g]) begin
                        w_next = ST_IN;
                    end else if (w_turn_done) begin
                        w_next = ST_OUT;
                    end else begin
                        w_next = ST_TURN_OUT;
                    end
                end
                ST_OUT: begin
                    if (oe_req[g]) begin
                        w_next = ST_OUT;
                    end else if (TURNAROUND == 0) begin
                        w_next = ST_IN;
                    end else begin
                        w_next = ST_TURN_IN;
                    end
                end
                ST_TURN_IN: begin
                    if (w_turn_done) begin
                        w_next = ST_IN;
                    end else begin
                        w_next = ST_TURN_IN;
                    end
                end
                default: w_next = ST_IN;
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        always_comb begin
            w_pad_t   = 1'b0;
            w_ibuf_en = 1'b0;
            w_busy    = 1'b0;
            case (w_next)
                ST_IN:       w_ibuf_en = 1'b1;
                ST_TURN_OUT: w_busy    = 1'b1;
                ST_OUT:      w_pad_t   = 1'b1;
                ST_TURN_IN:  w_busy    = 1'b1;
                default:     w_ibuf_en = 1'b1;
            endcase
        end

        // State, registered outputs and turnaround counter (restarts on every state change).
        always_ff @(posedge C or negedge R) begin
            if (!R) begin
                r_state   <= ST_IN;
                r_tcnt    <= '0;
                r_pad_t   <= 1'b0;
                r_ibuf_en <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                r_state   <= w_next;
                r_pad_t   <= w_pad_t;
                r_ibuf_en <= w_ibuf_en;
                r_busy    <= w_busy;
                if (w_next != r_state) begin
                    r_tcnt <= '0;
                end else if (r_tcnt != CMAX) begin
                    r_tcnt <= r_tcnt + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    r_tcnt <= r_tcnt;
                end
            end
        end

        assign w_upd = (r_state == ST_IN) && (r_sync != r_in) && (FBYPASS || (r_fcnt == FCMP));

        // Synchroniser, glitch filter and edge pulses; in_data frozen outside IN.
        always_ff @(posedge C or negedge R) begin
            if (!R) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_in   <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_fcnt <= '0;
            end else begin
                r_meta <= pad_i[g];
                r_sync <= r_meta;
                r_rise <= w_upd & r_sync;
                r_fall <= w_upd & ~r_sync;
                if (w_upd) begin
                    r_in <= r_sync;
                end else begin
                    r_in <= r_in;
                end
                if ((r_state != ST_IN) || (r_sync == r_in) || w_upd) begin
                    r_fcnt <= '0;
                end else if (r_fcnt != CMAX) begin
                    r_fcnt <= r_fcnt + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    r_fcnt <= r_fcnt;
                end
            end
        end

        assign pad_t[g]   = r_pad_t;
        assign ibuf_en[g] = r_ibuf_en;
        assign busy[g]    = r_busy;
        assign in_data[g] = r_in;
        assign rise[g]    = r_rise;
        assign fall[g]    = r_fall;
    end

endmodule
